// File: rtl/alu_issue_if.sv
// Handshake bundle between the decode/register-read side and the ALU issue stage.
// The bench drives the upstream offer and the downstream ready through the master modport.
interface alu_issue_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] instr;
   logic [31:0] rs_value;
   logic [31:0] rt_value;
   logic        out_valid;
   logic        out_ready;
   logic [2:0]  ALU_operation;
   logic [31:0] input_1;
   logic [31:0] input_2;
   logic [4:0]  dest_reg;

   modport master (
      output in_valid, instr, rs_value, rt_value, out_ready,
      input  in_ready, out_valid, ALU_operation, input_1, input_2, dest_reg
   );

   modport slave (
      input  in_valid, instr, rs_value, rt_value, out_ready,
      output in_ready, out_valid, ALU_operation, input_1, input_2, dest_reg
   );
endinterface

// File: rtl/alu_issue_stage.sv
// MIPS ALU issue stage: decodes one instruction into an ALU command behind a 2-entry skid buffer.
// Optional feature macro ALU_ISSUE_TRAP_EN: drop unsupported instructions and pulse `illegal`.
module alu_issue_stage #(
   parameter int ZERO_EXT_LOGIC = 1
) (
   input  logic        clk,
   input  logic        reset,
   alu_issue_if.slave  bus
`ifdef ALU_ISSUE_TRAP_EN
   ,
   output logic        illegal
`endif
);

   localparam logic [1:0] S_EMPTY = 2'b00;
   localparam logic [1:0] S_ONE   = 2'b01;
   localparam logic [1:0] S_TWO   = 2'b10;

   typedef struct packed {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  dst;
   } entry_t;

   function automatic logic signed [31:0] sext16(input logic [15:0] imm);
      return {{16{imm[15]}}, imm};
   endfunction

   function automatic logic [31:0] logic_imm(input logic [15:0] imm);
      return (ZERO_EXT_LOGIC != 0) ? {16'h0000, imm} : sext16(imm);
   endfunction

   logic [1:0] state_q, state_d;
   entry_t     main_q, main_d;
   entry_t     skid_q, skid_d;
   logic       rdy_q;
   entry_t     dec;
   logic       supported;
   logic       in_fire, out_fire, push;

   // Unsupported encodings fall through as an ADD with the routing their opcode implies.
   always_comb begin
      supported = 1'b1;
      dec.op    = 3'b010;
      dec.a     = bus.rs_value;
      dec.b     = bus.rt_value;
      dec.dst   = bus.instr[15:11];
      if (bus.instr[31:26] == 6'h00) begin
         case (bus.instr[5:0])
            6'h24:        dec.op = 3'b000;
            6'h25:        dec.op = 3'b001;
            6'h20, 6'h21: dec.op = 3'b010;
            6'h22, 6'h23: dec.op = 3'b110;
            6'h2A:        dec.op = 3'b111;
            default:      supported = 1'b0;
         endcase
      end else begin
         dec.b   = sext16(bus.instr[15:0]);
         dec.dst = bus.instr[20:16];
         case (bus.instr[31:26])
            6'h08, 6'h09: dec.op = 3'b010;
            6'h0A:        dec.op = 3'b111;
            6'h0C: begin
               dec.op = 3'b000;
               dec.b  = logic_imm(bus.instr[15:0]);
            end
            6'h0D: begin
               dec.op = 3'b001;
               dec.b  = logic_imm(bus.instr[15:0]);
            end
            default:      supported = 1'b0;
         endcase
      end
   end

   assign bus.in_ready      = rdy_q && (state_q != S_TWO);
   assign bus.out_valid     = (state_q == S_ONE) || (state_q == S_TWO);
   assign bus.ALU_operation = main_q.op;
   assign bus.input_1       = main_q.a;
   assign bus.input_2       = main_q.b;
   assign bus.dest_reg      = main_q.dst;

   assign in_fire  = bus.in_valid && bus.in_ready;
   assign out_fire = bus.out_valid && bus.out_ready;

`ifdef ALU_ISSUE_TRAP_EN
   logic illegal_q;

   assign push    = in_fire && supported;
   assign illegal = illegal_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) illegal_q <= 1'b0;
      else       illegal_q <= in_fire && !supported;
   end
`else
   logic unused_supported;

   assign push             = in_fire;
   assign unused_supported = supported;
`endif

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      case (state_q)
         S_EMPTY: begin
            if (push) begin
               state_d = S_ONE;
               main_d  = dec;
            end
         end
         S_ONE: begin
            if (push && out_fire) begin
               main_d = dec;
            end else if (push) begin
               state_d = S_TWO;
               skid_d  = dec;
            end else if (out_fire) begin
               state_d = S_EMPTY;
            end
         end
         S_TWO: begin
            if (out_fire) begin
               state_d = S_ONE;
               main_d  = skid_q;
            end
         end
         default: state_d = S_EMPTY;
      endcase
   end

   // rdy_q holds in_ready low until the first edge after reset is released.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_EMPTY;
         main_q  <= '0;
         rdy_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         rdy_q   <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      skid_q <= skid_d;
   end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Randomised bench for alu_issue_stage with a queue-based reference of the issue buffer.
// Two instances cover both immediate-extension modes; ALU_ISSUE_TRAP_EN selects the trap checks.
module tb_alu_issue_stage;

   typedef struct packed {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  d;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        out_ready;
   logic [31:0] instr;
   logic [31:0] rs_v;
   logic [31:0] rt_v;
   int          n_checks = 0;
   int          n_pass = 0;
   exp_t        q[$];

   logic [5:0] rfn [7] = '{6'h24, 6'h25, 6'h20, 6'h21, 6'h22, 6'h23, 6'h2A};
   logic [5:0] iop [5] = '{6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D};

   always #5 clk = ~clk;

   alu_issue_if bus ();
   alu_issue_if bus_z ();

   assign bus.in_valid    = in_valid;
   assign bus.instr       = instr;
   assign bus.rs_value    = rs_v;
   assign bus.rt_value    = rt_v;
   assign bus.out_ready   = out_ready;
   assign bus_z.in_valid  = in_valid;
   assign bus_z.instr     = instr;
   assign bus_z.rs_value  = rs_v;
   assign bus_z.rt_value  = rt_v;
   assign bus_z.out_ready = out_ready;

`ifdef ALU_ISSUE_TRAP_EN
   logic illegal, illegal_z;
   alu_issue_stage #(.ZERO_EXT_LOGIC(1)) dut (.clk(clk), .reset(reset), .bus(bus), .illegal(illegal));
   alu_issue_stage #(.ZERO_EXT_LOGIC(0)) dut_z (.clk(clk), .reset(reset), .bus(bus_z), .illegal(illegal_z));
`else
   alu_issue_stage #(.ZERO_EXT_LOGIC(1)) dut (.clk(clk), .reset(reset), .bus(bus));
   alu_issue_stage #(.ZERO_EXT_LOGIC(0)) dut_z (.clk(clk), .reset(reset), .bus(bus_z));
`endif

   function automatic logic [31:0] mk_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
      return {6'h00, rs, rt, rd, 5'h00, fn};
   endfunction

   function automatic logic [31:0] rand_instr();
      int k;
      k = $urandom_range(0, 11);
      if (k < 7)
         return {6'h00, 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), rfn[k]};
      return {iop[k-7], 5'($urandom), 5'($urandom), 16'($urandom)};
   endfunction

   // Reference meaning of each supported instruction (zero-extension mode fixed at 1).
   function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] rs,
                                       input logic [31:0] rt);
      exp_t        e;
      logic [31:0] simm, zimm;
      simm = {{16{ins[15]}}, ins[15:0]};
      zimm = {16'h0000, ins[15:0]};
      e.a  = rs;
      e.op = 3'b010;
      if (ins[31:26] == 6'h00) begin
         e.b = rt;
         e.d = ins[15:11];
         case (ins[5:0])
            6'h24:   e.op = 3'b000;
            6'h25:   e.op = 3'b001;
            6'h22,
            6'h23:   e.op = 3'b110;
            6'h2A:   e.op = 3'b111;
            default: e.op = 3'b010;
         endcase
      end else begin
         e.d = ins[20:16];
         case (ins[31:26])
            6'h0C:   begin e.op = 3'b000; e.b = zimm; end
            6'h0D:   begin e.op = 3'b001; e.b = zimm; end
            6'h0A:   begin e.op = 3'b111; e.b = simm; end
            default: begin e.op = 3'b010; e.b = simm; end
         endcase
      end
      return e;
   endfunction

   task automatic test_reset();
      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      instr = 32'h0; rs_v = 32'h0; rt_v = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if ({bus.out_valid, bus.in_ready, bus.ALU_operation, bus.dest_reg} !== 10'h0)
         $display("FAIL reset_ctrl: got %h want 0",
                  {bus.out_valid, bus.in_ready, bus.ALU_operation, bus.dest_reg});
      else n_pass++;
      n_checks++;
      if ({bus.input_1, bus.input_2} !== 64'h0)
         $display("FAIL reset_operands: got %h want 0", {bus.input_1, bus.input_2});
      else n_pass++;
      @(negedge clk);
      reset = 1'b0;
      #1;
      n_checks++;
      if (bus.in_ready !== 1'b0) $display("FAIL ready_before_edge: got %b want 0", bus.in_ready);
      else n_pass++;
      @(posedge clk);
      #1;
      n_checks++;
      if (bus.in_ready !== 1'b1) $display("FAIL ready_after_edge: got %b want 1", bus.in_ready);
      else n_pass++;
   endtask

   task automatic test_addi();
      in_valid = 1'b1; instr = 32'h2022FFFF; rs_v = 32'd5; rt_v = $urandom; out_ready = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      n_checks++;
      if ({bus.out_valid, bus.ALU_operation, bus.input_1, bus.input_2, bus.dest_reg} !==
          {1'b1, 3'b010, 32'd5, 32'hFFFFFFFF, 5'd2})
         $display("FAIL addi: got v=%b op=%b a=%h b=%h d=%0d want v=1 op=010 a=5 b=ffffffff d=2",
                  bus.out_valid, bus.ALU_operation, bus.input_1, bus.input_2, bus.dest_reg);
      else n_pass++;
      @(posedge clk);
      #1;
      n_checks++;
      if (bus.out_valid !== 1'b0) $display("FAIL addi_drain: got %b want 0", bus.out_valid);
      else n_pass++;
   endtask

   task automatic test_ori_ext();
      in_valid = 1'b1; instr = 32'h3443FFFF; rs_v = $urandom; out_ready = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      n_checks++;
      if ({bus.ALU_operation, bus.input_1, bus.input_2, bus.dest_reg} !==
          {3'b001, rs_v, 32'h0000FFFF, 5'd3})
         $display("FAIL ori_zext: got op=%b a=%h b=%h d=%0d want op=001 a=%h b=0000ffff d=3",
                  bus.ALU_operation, bus.input_1, bus.input_2, bus.dest_reg, rs_v);
      else n_pass++;
      n_checks++;
      if ({bus_z.ALU_operation, bus_z.input_2} !== {3'b001, 32'hFFFFFFFF})
         $display("FAIL ori_sext: got op=%b b=%h want op=001 b=ffffffff",
                  bus_z.ALU_operation, bus_z.input_2);
      else n_pass++;
      @(posedge clk);
      #1;
   endtask

   task automatic test_back_to_back();
      logic [31:0] i_sub, i_and, i_slt;
      i_sub = mk_r(5'd1, 5'd2, 5'd3, 6'h22);
      i_and = mk_r(5'd4, 5'd5, 5'd6, 6'h24);
      i_slt = mk_r(5'd7, 5'd8, 5'd9, 6'h2A);
      out_ready = 1'b0; in_valid = 1'b1; instr = i_sub;
      @(posedge clk);
      #1;
      instr = i_and;
      n_checks++;
      if (bus.in_ready !== 1'b1) $display("FAIL b2b_ready2: got %b want 1", bus.in_ready);
      else n_pass++;
      @(posedge clk);
      #1;
      instr = i_slt;
      n_checks++;
      if (bus.in_ready !== 1'b0) $display("FAIL b2b_ready3: got %b want 0", bus.in_ready);
      else n_pass++;
      @(posedge clk);
      #1;
      n_checks++;
      if ({bus.out_valid, bus.ALU_operation, bus.dest_reg} !== {1'b1, 3'b110, 5'd3})
         $display("FAIL b2b_stall_hold: got v=%b op=%b d=%0d want v=1 op=110 d=3",
                  bus.out_valid, bus.ALU_operation, bus.dest_reg);
      else n_pass++;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      n_checks++;
      if ({bus.ALU_operation, bus.dest_reg} !== {3'b000, 5'd6})
         $display("FAIL b2b_second: got op=%b d=%0d want op=000 d=6", bus.ALU_operation, bus.dest_reg);
      else n_pass++;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      n_checks++;
      if ({bus.out_valid, bus.ALU_operation, bus.dest_reg} !== {1'b1, 3'b111, 5'd9})
         $display("FAIL b2b_third: got v=%b op=%b d=%0d want v=1 op=111 d=9",
                  bus.out_valid, bus.ALU_operation, bus.dest_reg);
      else n_pass++;
      @(posedge clk);
      #1;
      n_checks++;
      if (bus.out_valid !== 1'b0) $display("FAIL b2b_empty: got %b want 0", bus.out_valid);
      else n_pass++;
   endtask

   // Drives n instructions with the given valid/ready percentages against the queue model.
   task automatic run_traffic(input string name, input int n, input int pv, input int pr,
                              input int want_cycles);
      int   sent, got, cyc;
      bit   in_fire, out_fire;
      exp_t e;
      sent = 0; got = 0; cyc = 0;
      q.delete();
      while ((sent < n || q.size() > 0) && cyc < 4000) begin
         in_valid  = (sent < n) && ($urandom_range(0, 99) < pv);
         out_ready = ($urandom_range(0, 99) < pr);
         instr     = rand_instr();
         rs_v      = $urandom;
         rt_v      = $urandom;
         n_checks++;
         if (bus.out_valid !== (q.size() > 0))
            $display("FAIL %s_valid cyc %0d: got %b want %b", name, cyc, bus.out_valid, q.size() > 0);
         else n_pass++;
         if (q.size() > 0) begin
            n_checks++;
            if ({bus.ALU_operation, bus.input_1, bus.input_2, bus.dest_reg} !== q[0])
               $display("FAIL %s_data cyc %0d: got %h want %h", name, cyc,
                        {bus.ALU_operation, bus.input_1, bus.input_2, bus.dest_reg}, q[0]);
            else n_pass++;
         end
         n_checks++;
         if (bus.in_ready !== (q.size() < 2))
            $display("FAIL %s_ready cyc %0d: got %b want %b", name, cyc, bus.in_ready, q.size() < 2);
         else n_pass++;
         e        = ref_decode(instr, rs_v, rt_v);
         in_fire  = in_valid && (q.size() < 2);
         out_fire = (q.size() > 0) && out_ready;
         @(posedge clk);
         #1;
         if (out_fire) begin
            void'(q.pop_front());
            got++;
         end
         if (in_fire) begin
            q.push_back(e);
            sent++;
         end
         cyc++;
      end
      in_valid = 1'b0;
      n_checks++;
      if (got !== n) $display("FAIL %s_count: got %0d want %0d", name, got, n);
      else n_pass++;
      if (want_cycles > 0) begin
         n_checks++;
         if (cyc !== want_cycles) $display("FAIL %s_cycles: got %0d want %0d", name, cyc, want_cycles);
         else n_pass++;
      end
   endtask

   task automatic test_stream();
      run_traffic("stream", 100, 100, 100, 101);
   endtask

   task automatic test_random_handshake();
      run_traffic("random", 300, 60, 50, 0);
   endtask

   task automatic test_async_reset();
      out_ready = 1'b0; in_valid = 1'b1; instr = rand_instr();
      repeat (2) @(posedge clk);
      #1;
      in_valid = 1'b0;
      n_checks++;
      if ({bus.out_valid, bus.in_ready} !== 2'b10)
         $display("FAIL arst_full: got v=%b r=%b want v=1 r=0", bus.out_valid, bus.in_ready);
      else n_pass++;
      #2;
      reset = 1'b1;
      #1;
      n_checks++;
      if ({bus.out_valid, bus.in_ready} !== 2'b00)
         $display("FAIL arst_immediate: got v=%b r=%b want 0 0", bus.out_valid, bus.in_ready);
      else n_pass++;
      @(negedge clk);
      reset = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      n_checks++;
      if ({bus.out_valid, bus.in_ready} !== 2'b01)
         $display("FAIL arst_release: got v=%b r=%b want v=0 r=1", bus.out_valid, bus.in_ready);
      else n_pass++;
      @(posedge clk);
      #1;
      n_checks++;
      if (bus.out_valid !== 1'b0) $display("FAIL arst_stale: got %b want 0", bus.out_valid);
      else n_pass++;
   endtask

   task automatic test_unsupported();
      out_ready = 1'b1; in_valid = 1'b1; instr = 32'hFC000000;
      rs_v = 32'h00000011; rt_v = 32'h00000022;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
`ifdef ALU_ISSUE_TRAP_EN
      n_checks++;
      if ({illegal, illegal_z, bus.out_valid} !== 3'b110)
         $display("FAIL trap_pulse: got ill=%b%b v=%b want ill=11 v=0", illegal, illegal_z, bus.out_valid);
      else n_pass++;
      @(posedge clk);
      #1;
      n_checks++;
      if ({illegal, bus.out_valid} !== 2'b00)
         $display("FAIL trap_end: got ill=%b v=%b want 0 0", illegal, bus.out_valid);
      else n_pass++;
`else
      n_checks++;
      if ({bus.out_valid, bus.ALU_operation, bus.input_1, bus.input_2, bus.dest_reg} !==
          {1'b1, 3'b010, 32'h11, 32'h0, 5'd0})
         $display("FAIL unsup_issue: got v=%b op=%b a=%h b=%h d=%0d want v=1 op=010 a=11 b=0 d=0",
                  bus.out_valid, bus.ALU_operation, bus.input_1, bus.input_2, bus.dest_reg);
      else n_pass++;
      @(posedge clk);
      #1;
      n_checks++;
      if (bus.out_valid !== 1'b0) $display("FAIL unsup_drain: got %b want 0", bus.out_valid);
      else n_pass++;
`endif
   endtask

   initial begin
      test_reset();
      test_addi();
      test_ori_ext();
      test_back_to_back();
      test_stream();
      test_random_handshake();
      test_async_reset();
      test_unsupported();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/alu_issue_stage.md
ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

Interface
REQ-001 Parameter ZERO_EXT_LOGIC, default 1, meaning: ANDI/ORI immediates are zero-extended when 1 and sign-extended when 0.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  upstream instruction and operands are valid.
REQ-005 in_ready  output  1  stage can accept a new instruction this cycle.
REQ-006 instr  input  32  MIPS instruction word.
REQ-007 rs_value  input  32  register-file value of rs.
REQ-008 rt_value  input  32  register-file value of rt.
REQ-009 out_valid  output  1  issued ALU command valid.
REQ-010 out_ready  input  1  ALU/writeback side accepts the command.
REQ-011 ALU_operation  output  3  ALU opcode: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT.
REQ-012 input_1  output  32  first ALU operand.
REQ-013 input_2  output  32  second ALU operand.
REQ-014 dest_reg  output  5  destination register number.
REQ-015 illegal  output  1  one-cycle pulse marking a dropped unsupported instruction (present only with ALU_ISSUE_TRAP_EN).

Function
REQ-016 A transfer SHALL occur on a rising edge when valid and ready are both high (in side and out side independently).
REQ-017 R-type (opcode 0x00) SHALL decode funct 0x24->000, 0x25->001, 0x20/0x21->010, 0x22/0x23->110, 0x2A->111; input_1=rs_value, input_2=rt_value, dest_reg=instr[15:11].
REQ-018 I-type SHALL decode opcode 0x08/0x09->010 sign-ext, 0x0A->111 sign-ext, 0x0C->000 and 0x0D->001 extended per ZERO_EXT_LOGIC; input_1=rs_value, input_2=extended instr[15:0], dest_reg=instr[20:16].
REQ-019 Any other opcode/funct SHALL be unsupported.
REQ-020 The stage SHALL hold a 2-entry buffer (main, skid) with states EMPTY, ONE, TWO.
REQ-021 All outputs except in_ready and illegal SHALL come from the main entry; out_valid=1 iff state is ONE or TWO.
REQ-022 in_ready SHALL be 1 iff state is not TWO.
REQ-023 Transitions: EMPTY+in->ONE; ONE+in only->TWO; ONE+out only->EMPTY; ONE+in+out->ONE (new entry to main); TWO+out->ONE (skid moves to main); all other cases hold state.
REQ-024 Latency SHALL be exactly one cycle: an instruction accepted at edge N presents out_valid at edge N when the buffer was EMPTY, or directly behind older entries otherwise.
REQ-025 Order SHALL be preserved; no entry is lost or duplicated under any in/out handshake pattern.
REQ-026 Main-entry outputs SHALL remain stable while out_valid=1 and out_ready=0.

Reset
REQ-027 While reset is high: state EMPTY, out_valid=0, illegal=0, ALU_operation=000, input_1=0, input_2=0, dest_reg=0, in_ready=0.
REQ-028 in_ready SHALL rise on the first clock edge after reset deasserts; buffered entries at reset assertion SHALL be discarded.

Configuration
REQ-029 With ALU_ISSUE_TRAP_EN defined: unsupported instructions SHALL be accepted, not buffered, and pulse illegal for one cycle.
REQ-030 Without ALU_ISSUE_TRAP_EN: illegal port absent; unsupported instructions SHALL issue as ALU_operation 010 with R-type/I-type operand routing per opcode.

Verification
REQ-031 ADDI instr=0x2022FFFF, rs_value=5, out_ready=1 -> next cycle out_valid=1, ALU_operation=010, input_2=0xFFFFFFFF, dest_reg=2.
REQ-032 ORI instr=0x3443FFFF with ZERO_EXT_LOGIC=1 -> input_2=0x0000FFFF, ALU_operation=001; with ZERO_EXT_LOGIC=0 -> input_2=0xFFFFFFFF.
REQ-033 out_ready=0, three back-to-back SUB/AND/SLT offers -> first two accepted, in_ready=0 on third; releasing out_ready drains 110, 000, 111 in order.
REQ-034 Continuous in_valid and out_ready with 100 random supported instructions -> 100 outputs in order, zero bubbles after the first.
REQ-035 Reset asserted asynchronously with state TWO -> out_valid=0 and in_ready=0 immediately, no stale entry after release.
REQ-036 instr=0xFC000000 -> illegal=1 for one cycle and no out_valid with ALU_ISSUE_TRAP_EN; ALU_operation=010 issued without.
